// File: rtl/apb_pkg.sv
// Shared APB requester definitions: bus widths, FSM encoding and timeout sizing.
package apb_pkg;
  localparam int APB_ADDR_W      = 8;
  localparam int APB_DATA_W      = 8;
  localparam int APB_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } apb_state_e;

  // One spare bit above clog2 lets the counter saturate past the terminal count.
  function automatic int wait_cnt_w(input int tmo);
    return $clog2(tmo) + 1;
  endfunction
endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS wait-state counter with terminal-count flag; TIMEOUT=0 never fires.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT = APB_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  localparam int                CNT_W  = wait_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_TC  = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_cnt <= '0;
    else if (i_clr)                   r_cnt <= '0;
    else if (i_en && r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_tc = (TIMEOUT != 0) && (r_cnt == CNT_TC);
endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: single valid/ready command in, SETUP/ACCESS on the bus, one-cycle response strobe.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = APB_TIMEOUT_DEF
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);
  apb_state_e r_state;
  logic       w_wait_clr;
  logic       w_wait_en;
  logic       w_wait_tc;

  assign cmd_ready  = (r_state == ST_IDLE);
  assign w_wait_clr = (r_state == ST_SETUP);
  assign w_wait_en  = (r_state == ST_ACCESS) && !PREADY;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk   (PCLK),
    .rst   (PRESET),
    .i_clr (w_wait_clr),
    .i_en  (w_wait_en),
    .o_tc  (w_wait_tc)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state     <= ST_IDLE;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            PADDR   <= cmd_addr;
            PWRITE  <= cmd_write;
            PWDATA  <= cmd_wdata;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // PRDATA/PSLVERR are only meaningful on the completing edge.
          if (PREADY) begin
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            r_state     <= ST_IDLE;
          end else if (w_wait_tc) begin
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB requester (initiator) driving an 8-bit APB bus, e.g. into the LED register completer on the fabric APB segment.
- Accepts single read/write commands on a valid/ready command port, runs APB SETUP/ACCESS phases and honours PREADY wait states.
- Returns read data and error status on a one-cycle response strobe.
- A programmable timeout aborts transfers whose completer never asserts PREADY.

Parameters:
ADDR_W, 8, width of cmd_addr and PADDR
DATA_W, 8, width of cmd_wdata, PWDATA, PRDATA, rsp_rdata
TIMEOUT, 16, max ACCESS cycles with PREADY=0 before abort; 0 disables timeout

Ports:
PCLK  in  1  bus clock; all flops on rising edge
PRESET  in  1  asynchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  bridge can accept command (high only in IDLE)
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  byte address; completers decode PADDR[5:2], bridge passes all bits unchanged
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
rsp_err  out  1  PSLVERR seen or timeout
rsp_timeout  out  1  transfer aborted by timeout
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data
PREADY  in  1  completer ready
PSLVERR  in  1  completer error

Behaviour:
- Reset values (PRESET high, asynchronous): state=IDLE; PSEL, PENABLE, PWRITE=0; PADDR, PWDATA=0; rsp_valid, rsp_err, rsp_timeout=0; rsp_rdata=0; wait counter=0.
- cmd_ready = (state==IDLE), combinational from state. It may read 1 during reset, but nothing is captured while PRESET is high.
- All APB outputs and rsp_* are registered.
- States:
  - IDLE: on cmd_valid&cmd_ready at edge N, latch cmd into PADDR/PWRITE/PWDATA, set PSEL=1, PENABLE=0 -> SETUP.
  - SETUP: exactly one cycle. Set PENABLE=1, clear wait counter -> ACCESS.
  - ACCESS: PREADY sampled each edge.
    - PREADY=1: PSEL=0, PENABLE=0, rsp_valid=1, rsp_err=PSLVERR, rsp_rdata = PWRITE ? 0 : PRDATA, rsp_timeout=0 -> IDLE.
    - PREADY=0 and (TIMEOUT==0 or counter<TIMEOUT-1): counter++, stay, all APB outputs held stable.
    - PREADY=0 and TIMEOUT!=0 and counter==TIMEOUT-1: PSEL=0, PENABLE=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0 -> IDLE.
- Latency: accept at edge N, SETUP in cycle N+1, ACCESS in N+2. With zero wait states, rsp_valid is high in cycle N+3 for exactly one cycle; each wait state adds one cycle.
- Throughput: one transfer per 3 cycles minimum. cmd_ready is high in the cycle rsp_valid is high, so back-to-back acceptance is allowed in that cycle.
- PSLVERR and PRDATA are ignored except on the PREADY=1 ACCESS edge.
- PADDR/PWDATA/PWRITE keep their last values after a transfer (no toggling in IDLE).
- Wait counter: width clog2(TIMEOUT)+1, saturates, never wraps.
- cmd_* changes while cmd_ready=0 are ignored; the no-backpressure response is never stalled.
- Reset mid-transfer: bus returns to the reset state immediately (PSEL=0 asynchronously). No response is issued for the aborted command.

Decomposition:
- Package apb_pkg:
  - state enum (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10)
  - APB_ADDR_W=8, APB_DATA_W=8
  - default TIMEOUT constant
- One natural sub-module: apb_wait_timer (counter + terminal-count flag, inputs clr/en, parameter TIMEOUT), reusable by other APB requesters.
- FSM and datapath stay in apb_master_bridge.

Test Plan:
- Write, zero-wait: cmd_write=1, addr=0x04, wdata=0xA5 accepted at N, completer PREADY=1 -> PSEL=1 N+1..N+2, PENABLE=1 N+2 only, PWDATA=0xA5, rsp_valid N+3, rsp_err=0.
- Read, 3 wait states: addr=0x08, completer holds PREADY=0 for 3 ACCESS cycles, PRDATA=0x3C -> PENABLE high 4 cycles, PADDR stable throughout, rsp_rdata=0x3C at N+6.
- Error: read with PSLVERR=1 on the PREADY edge -> rsp_valid=1, rsp_err=1, rsp_timeout=0. A following write is accepted in the rsp_valid cycle and runs normally.
- Timeout: TIMEOUT=4, PREADY tied 0 -> exactly 4 ACCESS cycles, then PSEL=PENABLE=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0, cmd_ready=1. With TIMEOUT=0, PREADY=0 for 100 cycles -> no abort.
- Reset mid-ACCESS: assert PRESET during wait state -> PSEL, PENABLE, rsp_valid=0 without a clock edge. After release, no rsp_valid, cmd_ready=1, a new read completes normally.
- Back-to-back: cmd_valid held high with 4 writes, PREADY=1 -> 4 rsp_valid pulses spaced 3 cycles, no overlap of PSEL between transfers except SETUP following IDLE-cycle accept.
